// File: rtl/idft_job_sequencer.sv
// Wishbone job sequencer for an IDFT accelerator: copies LEN words SRC -> accelerator input,
// starts it, polls for done, then copies the output window to DST. Configured via a Wishbone slave.
module idft_job_sequencer #(
    parameter logic [31:0] ACC_BASE   = 32'h0000_0000,
    parameter logic [31:0] IN_OFS     = 32'h0000_0000,
    parameter logic [31:0] OUT_OFS    = 32'h0000_0100,
    parameter logic [31:0] CTRL_OFS   = 32'h0000_0200,
    parameter logic [31:0] STAT_OFS   = 32'h0000_0204,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_sys_n,

    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,

    output logic        irq
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SRC,
        S_WR_IN,
        S_START,
        S_POLL,
        S_RD_OUT,
        S_WR_DST,
        S_DONE,
        S_ERR
    } state_t;

    // The poll counter is 10 bits wide, so POLL_LIMIT above 1024 cannot be honoured.
    localparam logic [31:0] POLL_LAST = 32'(POLL_LIMIT - 1);

    state_t      state, state_nxt;

    logic [31:0] src_q, dst_q, hold_q;
    logic [4:0]  len_q;
    logic [3:0]  idx_q;
    logic [9:0]  poll_cnt_q;
    logic        done_q, err_q;

    logic [1:0]  slv_reg;
    logic        slv_acc, slv_wr, start_req, clear_req, busy;
    logic [31:0] slv_rd_data;

    logic        m_ack, m_err, last_word, poll_last;
    logic        xfer_req, xfer_we;
    logic [31:0] xfer_adr, xfer_dat, word_ofs;

    logic        unused_inputs;

    function automatic logic [4:0] clamp_len(input logic [31:0] d);
        if (d == 32'd0 || d > 32'd16)
            return 5'd16;
        return d[4:0];
    endfunction

    assign unused_inputs = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i, wbm_rty_i};

    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;
    assign wbm_sel_o = 4'hF;

    assign slv_reg   = wbs_adr_i[3:2];
    assign slv_acc   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign slv_wr    = slv_acc & wbs_we_i;
    assign busy      = (state != S_IDLE);
    assign clear_req = slv_wr & (slv_reg == 2'd3) & wbs_dat_i[1];
    assign start_req = slv_wr & (slv_reg == 2'd3) & wbs_dat_i[0] & ~busy;

    assign m_ack     = wbm_cyc_o & wbm_ack_i;
    assign m_err     = wbm_cyc_o & wbm_err_i;
    assign last_word = ({1'b0, idx_q} == (len_q - 5'd1));
    assign poll_last = ({22'b0, poll_cnt_q} >= POLL_LAST);
    assign word_ofs  = {26'b0, idx_q, 2'b00};

    always_comb begin
        case (slv_reg)
            2'd0:    slv_rd_data = src_q;
            2'd1:    slv_rd_data = dst_q;
            2'd2:    slv_rd_data = {27'b0, len_q};
            default: slv_rd_data = {29'b0, busy, err_q, done_q};
        endcase
    end

    // Configuration slave; clear is applied before DONE/ERR set so a same-cycle event is not lost.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            src_q     <= 32'h0;
            dst_q     <= 32'h0;
            len_q     <= 5'd16;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= slv_acc;
            if (slv_acc && !wbs_we_i)
                wbs_dat_o <= slv_rd_data;
            if (slv_wr && !busy) begin
                case (slv_reg)
                    2'd0:    src_q <= {wbs_dat_i[31:2], 2'b00};
                    2'd1:    dst_q <= {wbs_dat_i[31:2], 2'b00};
                    2'd2:    len_q <= clamp_len(wbs_dat_i);
                    default: ;
                endcase
            end
            if (clear_req) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                irq    <= 1'b0;
            end
            if (state == S_DONE) begin
                done_q <= 1'b1;
                irq    <= 1'b1;
            end
            if (state == S_ERR) begin
                err_q <= 1'b1;
                irq   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        xfer_req  = 1'b0;
        xfer_we   = 1'b0;
        xfer_adr  = 32'h0;
        xfer_dat  = 32'h0;
        case (state)
            S_IDLE: begin
                if (start_req)
                    state_nxt = S_RD_SRC;
            end
            S_RD_SRC: begin
                xfer_req = 1'b1;
                xfer_adr = src_q + word_ofs;
                if (m_ack)
                    state_nxt = S_WR_IN;
            end
            S_WR_IN: begin
                xfer_req = 1'b1;
                xfer_we  = 1'b1;
                xfer_adr = ACC_BASE + IN_OFS + word_ofs;
                xfer_dat = hold_q;
                if (m_ack)
                    state_nxt = last_word ? S_START : S_RD_SRC;
            end
            S_START: begin
                xfer_req = 1'b1;
                xfer_we  = 1'b1;
                xfer_adr = ACC_BASE + CTRL_OFS;
                xfer_dat = 32'h1;
                if (m_ack)
                    state_nxt = S_POLL;
            end
            S_POLL: begin
                xfer_req = 1'b1;
                xfer_adr = ACC_BASE + STAT_OFS;
                if (m_ack) begin
                    if (wbm_dat_i[0])
                        state_nxt = S_RD_OUT;
                    else if (poll_last)
                        state_nxt = S_ERR;
                end
            end
            S_RD_OUT: begin
                xfer_req = 1'b1;
                xfer_adr = ACC_BASE + OUT_OFS + word_ofs;
                if (m_ack)
                    state_nxt = S_WR_DST;
            end
            S_WR_DST: begin
                xfer_req = 1'b1;
                xfer_we  = 1'b1;
                xfer_adr = dst_q + word_ofs;
                xfer_dat = hold_q;
                if (m_ack)
                    state_nxt = last_word ? S_DONE : S_RD_OUT;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (m_err)
            state_nxt = S_ERR;
    end

    // Master bus: a request is raised the cycle after entering a transfer state and dropped the
    // cycle after ack/err. rty is not a termination, so the request simply stays up and the
    // slave sees the same transfer again on the next cycle.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            hold_q    <= 32'h0;
        end else begin
            if (wbm_cyc_o) begin
                if (wbm_ack_i || wbm_err_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                end
            end else if (xfer_req) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= xfer_we;
                wbm_adr_o <= xfer_adr;
                wbm_dat_o <= xfer_dat;
            end
            if (m_ack && !wbm_we_o)
                hold_q <= wbm_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            idx_q      <= 4'd0;
            poll_cnt_q <= 10'd0;
        end else begin
            if ((state == S_IDLE && state_nxt == S_RD_SRC) ||
                (state == S_POLL && state_nxt == S_RD_OUT))
                idx_q <= 4'd0;
            else if (m_ack && (state == S_WR_IN || state == S_WR_DST))
                idx_q <= idx_q + 4'd1;
            if (state == S_START && state_nxt == S_POLL)
                poll_cnt_q <= 10'd0;
            else if (state == S_POLL && m_ack)
                poll_cnt_q <= poll_cnt_q + 10'd1;
        end
    end

endmodule

// File: tb/tb_idft_job_sequencer.sv
// Directed bench for idft_job_sequencer: register vector table plus hand-written job sequences
// against a bus model of source/destination memory and the IDFT accelerator.
module tb_idft_job_sequencer;

    localparam logic [31:0] A_SRC  = 32'h0;
    localparam logic [31:0] A_DST  = 32'h4;
    localparam logic [31:0] A_LEN  = 32'h8;
    localparam logic [31:0] A_CTRL = 32'hC;

    logic        clk = 1'b0;
    logic        rst_sys_n;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] m_dat = 32'h0;
    logic        m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    idft_job_sequencer dut (
        .clk(clk), .rst_sys_n(rst_sys_n),
        .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_sel_i(s_sel),
        .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(m_dat), .wbm_ack_i(m_ack), .wbm_err_i(m_err), .wbm_rty_i(m_rty),
        .irq(irq)
    );

    // Bus model controls (driven by the test) and observations (driven by the model)
    int   done_after, err_wr_in_n;
    logic rty_src, stat_clr;
    int   polls, rd_src_cnt, wr_in_try, wr_in_cnt, start_cnt, rd_out_cnt, wr_dst_cnt;
    int   bad_attr = 0;
    logic rty_done;
    logic [31:0] src_adr[16], in_adr[16], in_dat[16], out_adr[16], dst_adr[16], dst_dat[16];

    always @(posedge clk) begin
        m_ack <= 1'b0;
        m_err <= 1'b0;
        m_rty <= 1'b0;
        if (stat_clr) begin
            polls <= 0; rd_src_cnt <= 0; wr_in_try <= 0; wr_in_cnt <= 0;
            start_cnt <= 0; rd_out_cnt <= 0; wr_dst_cnt <= 0; rty_done <= 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o && !m_ack && !m_err && !m_rty) begin
            if (wbm_cti_o != 3'b000 || wbm_bte_o != 2'b00 || wbm_sel_o != 4'hF)
                bad_attr <= bad_attr + 1;
            if (wbm_we_o) begin
                if (wbm_adr_o < 32'h100) begin
                    wr_in_try <= wr_in_try + 1;
                    if (wr_in_try + 1 == err_wr_in_n) begin
                        m_err <= 1'b1;
                    end else begin
                        if (wr_in_cnt < 16) begin
                            in_adr[wr_in_cnt] <= wbm_adr_o;
                            in_dat[wr_in_cnt] <= wbm_dat_o;
                        end
                        wr_in_cnt <= wr_in_cnt + 1;
                        m_ack <= 1'b1;
                    end
                end else if (wbm_adr_o == 32'h200) begin
                    if (wbm_dat_o != 32'h1)
                        bad_attr <= bad_attr + 1;
                    start_cnt <= start_cnt + 1;
                    m_ack <= 1'b1;
                end else begin
                    if (wr_dst_cnt < 16) begin
                        dst_adr[wr_dst_cnt] <= wbm_adr_o;
                        dst_dat[wr_dst_cnt] <= wbm_dat_o;
                    end
                    wr_dst_cnt <= wr_dst_cnt + 1;
                    m_ack <= 1'b1;
                end
            end else begin
                if (wbm_adr_o == 32'h204) begin
                    polls <= polls + 1;
                    m_dat <= (done_after != 0 && polls + 1 >= done_after) ? 32'h1 : 32'h0;
                    m_ack <= 1'b1;
                end else if (wbm_adr_o >= 32'h100 && wbm_adr_o < 32'h200) begin
                    if (rd_out_cnt < 16)
                        out_adr[rd_out_cnt] <= wbm_adr_o;
                    rd_out_cnt <= rd_out_cnt + 1;
                    m_dat <= 32'hC0 + ((wbm_adr_o - 32'h100) >> 2);
                    m_ack <= 1'b1;
                end else if (rty_src && !rty_done) begin
                    m_rty    <= 1'b1;
                    rty_done <= 1'b1;
                end else begin
                    if (rd_src_cnt < 16)
                        src_adr[rd_src_cnt] <= wbm_adr_o;
                    rd_src_cnt <= rd_src_cnt + 1;
                    m_dat <= 32'hA0 + ((wbm_adr_o - 32'h1000) >> 2);
                    m_ack <= 1'b1;
                end
            end
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = 32'h0;
        @(posedge clk); #1;
        s_adr = a; s_dat = d; s_we = we; s_cyc = 1'b1; s_stb = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                got = 1'b1;
                rd  = wbs_dat_o;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        if (!got)
            chk("wbs_ack_timeout", 32'(got), 32'h1);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, a, 32'h0, v);
        chk(nm, v, exp);
    endtask

    task automatic wait_irq(input int maxc);
        logic got;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(posedge clk); #1;
            if (irq) got = 1'b1;
        end
        if (!got)
            chk("irq_timeout", 32'(got), 32'h1);
    endtask

    task automatic clear_stats();
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, A_SRC,  32'h0000_1003, 32'h0};
        vecs[1]  = '{1'b0, A_SRC,  32'h0,         32'h0000_1000};
        vecs[2]  = '{1'b1, A_DST,  32'h0000_2002, 32'h0};
        vecs[3]  = '{1'b0, A_DST,  32'h0,         32'h0000_2000};
        vecs[4]  = '{1'b1, A_LEN,  32'h0,         32'h0};
        vecs[5]  = '{1'b0, A_LEN,  32'h0,         32'd16};
        vecs[6]  = '{1'b1, A_LEN,  32'h0000_0103, 32'h0};
        vecs[7]  = '{1'b0, A_LEN,  32'h0,         32'd16};
        vecs[8]  = '{1'b1, A_LEN,  32'd17,        32'h0};
        vecs[9]  = '{1'b0, A_LEN,  32'h0,         32'd16};
        vecs[10] = '{1'b1, A_LEN,  32'd1,         32'h0};
        vecs[11] = '{1'b0, A_LEN,  32'h0,         32'd1};
        vecs[12] = '{1'b1, A_LEN,  32'd4,         32'h0};
        vecs[13] = '{1'b0, A_LEN,  32'h0,         32'd4};
        vecs[14] = '{1'b0, A_CTRL, 32'h0,         32'h0};
        vecs[15] = '{1'b1, A_SRC,  32'h0000_1000, 32'h0};
        vecs[16] = '{1'b0, A_SRC,  32'h0,         32'h0000_1000};
        vecs[17] = '{1'b1, A_DST,  32'h0000_2000, 32'h0};

        rst_sys_n = 1'b0;
        s_adr = 32'h0; s_dat = 32'h0; s_sel = 4'hF; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        done_after = 3; err_wr_in_n = 0; rty_src = 1'b0; stat_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wbs_out", {wbs_dat_o[28:0], wbs_ack_o, wbs_err_o, wbs_rty_o}, 32'h0);
        chk("rst_wbm_ctl", {27'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, irq, 1'b0}, 32'h0);
        chk("rst_wbm_adr", wbm_adr_o, 32'h0);
        rst_sys_n = 1'b1;
        stat_clr  = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].we)
                wb_wr(vecs[i].adr, vecs[i].dat);
            else
                rd_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
        end

        // ack pulses with a gap while stb is held
        @(posedge clk); #1;
        s_adr = A_CTRL; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ack_pulse%0d", k), 32'(wbs_ack_o), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        s_cyc = 1'b0; s_stb = 1'b0;

        // basic 4-word job, accelerator done on 3rd poll
        clear_stats();
        done_after = 3;
        wb_wr(A_CTRL, 32'h1);
        rd_chk("job1_stat_busy", A_CTRL, 32'h4);
        wait_irq(2000);
        chk("job1_rd_src", 32'(rd_src_cnt), 32'd4);
        chk("job1_wr_in", 32'(wr_in_cnt), 32'd4);
        chk("job1_start", 32'(start_cnt), 32'd1);
        chk("job1_polls", 32'(polls), 32'd3);
        chk("job1_rd_out", 32'(rd_out_cnt), 32'd4);
        chk("job1_wr_dst", 32'(wr_dst_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("job1_src_adr%0d", i), src_adr[i], 32'h1000 + 32'(4 * i));
            chk($sformatf("job1_in_adr%0d", i), in_adr[i], 32'(4 * i));
            chk($sformatf("job1_in_dat%0d", i), in_dat[i], 32'hA0 + 32'(i));
            chk($sformatf("job1_out_adr%0d", i), out_adr[i], 32'h100 + 32'(4 * i));
            chk($sformatf("job1_dst_adr%0d", i), dst_adr[i], 32'h2000 + 32'(4 * i));
            chk($sformatf("job1_dst_dat%0d", i), dst_dat[i], 32'hC0 + 32'(i));
        end
        rd_chk("job1_stat", A_CTRL, 32'h1);
        chk("job1_irq", 32'(irq), 32'h1);

        // clear+start together, then writes while busy are ignored
        clear_stats();
        done_after = 1;
        wb_wr(A_CTRL, 32'h3);
        chk("job2_irq_cleared", 32'(irq), 32'h0);
        rd_chk("job2_stat_busy", A_CTRL, 32'h4);
        wb_wr(A_SRC, 32'h0000_3000);
        wb_wr(A_LEN, 32'd2);
        wb_wr(A_CTRL, 32'h1);
        wait_irq(2000);
        chk("job2_rd_src", 32'(rd_src_cnt), 32'd4);
        chk("job2_src_adr3", src_adr[3], 32'h100C);
        chk("job2_polls", 32'(polls), 32'd1);
        rd_chk("job2_src_kept", A_SRC, 32'h1000);
        rd_chk("job2_len_kept", A_LEN, 32'd4);
        repeat (30) @(posedge clk);
        #1;
        chk("job2_no_restart", 32'(start_cnt), 32'd1);

        // 16-word job (LEN written as 0) with a retry on the first source read
        clear_stats();
        rty_src = 1'b1;
        wb_wr(A_LEN, 32'h0);
        wb_wr(A_CTRL, 32'h3);
        wait_irq(3000);
        rty_src = 1'b0;
        chk("job3_rd_src", 32'(rd_src_cnt), 32'd16);
        chk("job3_wr_in", 32'(wr_in_cnt), 32'd16);
        chk("job3_in_dat0", in_dat[0], 32'hA0);
        chk("job3_in_dat15", in_dat[15], 32'hAF);
        chk("job3_in_adr15", in_adr[15], 32'h3C);
        chk("job3_wr_dst", 32'(wr_dst_cnt), 32'd16);
        chk("job3_dst_adr15", dst_adr[15], 32'h203C);
        chk("job3_dst_dat15", dst_dat[15], 32'hCF);
        rd_chk("job3_stat", A_CTRL, 32'h1);

        // accelerator never finishes -> poll timeout
        clear_stats();
        done_after = 0;
        wb_wr(A_CTRL, 32'h3);
        wait_irq(8000);
        chk("job4_polls", 32'(polls), 32'd1024);
        chk("job4_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("job4_irq", 32'(irq), 32'h1);
        rd_chk("job4_stat", A_CTRL, 32'h2);

        // bus error on the 2nd input-window write
        clear_stats();
        done_after = 1;
        err_wr_in_n = 2;
        wb_wr(A_LEN, 32'd4);
        wb_wr(A_CTRL, 32'h3);
        wait_irq(500);
        err_wr_in_n = 0;
        chk("job5_wr_in", 32'(wr_in_cnt), 32'd1);
        chk("job5_no_start", 32'(start_cnt), 32'd0);
        chk("job5_cyc", 32'(wbm_cyc_o), 32'h0);
        rd_chk("job5_stat", A_CTRL, 32'h2);
        wb_wr(A_CTRL, 32'h2);
        rd_chk("job5_stat_clr", A_CTRL, 32'h0);
        chk("job5_irq_clr", 32'(irq), 32'h0);

        // asynchronous reset while a poll is on the bus
        clear_stats();
        done_after = 0;
        wb_wr(A_CTRL, 32'h1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin
                @(posedge clk); #1;
                if (polls >= 2 && wbm_cyc_o && wbm_adr_o == 32'h204) seen = 1'b1;
            end
            chk("job6_poll_seen", 32'(seen), 32'h1);
        end
        #2;
        rst_sys_n = 1'b0;
        #1;
        chk("job6_async_cyc", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        @(posedge clk); #1;
        rst_sys_n = 1'b1;
        rd_chk("job6_stat", A_CTRL, 32'h0);
        rd_chk("job6_len", A_LEN, 32'd16);
        rd_chk("job6_src", A_SRC, 32'h0);

        chk("slave_err_rty", {30'b0, wbs_err_o, wbs_rty_o}, 32'h0);
        chk("master_attrs", 32'(bad_attr), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/idft_job_sequencer.md
IDFT_JOB_SEQUENCER -- requirements
Module: idft_job_sequencer

Interface
REQ-001 SHALL have parameter ACC_BASE, default 32'h0000_0000: Wishbone base address of the IDFT accelerator slave.
REQ-002 SHALL have parameter IN_OFS, default 32'h0000_0000: accelerator input-window byte offset.
REQ-003 SHALL have parameter OUT_OFS, default 32'h0000_0100: accelerator output-window byte offset.
REQ-004 SHALL have parameter CTRL_OFS, default 32'h0000_0200: accelerator start register byte offset.
REQ-005 SHALL have parameter STAT_OFS, default 32'h0000_0204: accelerator status register byte offset; bit0 = done.
REQ-006 SHALL have parameter POLL_LIMIT, default 1024: maximum status polls before timeout.
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_sys_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have slave inputs wbs_adr_i (32), wbs_dat_i (32), wbs_sel_i (4), wbs_cyc_i, wbs_stb_i and wbs_we_i (1 each): configuration port.
REQ-010 SHALL have slave outputs wbs_dat_o (32), wbs_ack_o, wbs_err_o and wbs_rty_o (1 each).
REQ-011 SHALL have master outputs wbm_adr_o (32), wbm_dat_o (32), wbm_sel_o (4), wbm_cyc_o, wbm_stb_o, wbm_we_o (1 each), wbm_cti_o (3) and wbm_bte_o (2).
REQ-012 SHALL have master inputs wbm_dat_i (32), wbm_ack_i, wbm_err_i and wbm_rty_i (1 each).
REQ-013 SHALL have output irq, 1: job complete or job error, level, sticky until cleared.

Function
REQ-014 Slave register map, wbs_adr_i[3:2]: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STAT.
REQ-015 SRC and DST SHALL be byte addresses; bits [1:0] SHALL be forced to 0.
REQ-016 LEN SHALL be 5 bits, 1..16 words; writing 0 or >16 SHALL store 16.
REQ-017 A CTRL write with bit0=1 SHALL start a job only in IDLE; in any other state it SHALL be ignored.
REQ-018 A CTRL write with bit1=1 SHALL clear done, err and irq; a write with bit0=1 and bit1=1 in IDLE SHALL clear first, then start.
REQ-019 A STAT read SHALL return {29'b0, busy, err, done}.
REQ-020 Writes to SRC, DST and LEN while busy SHALL be ignored; reads SHALL always be allowed.
REQ-021 wbs_ack_o SHALL be a one-cycle pulse, one cycle after cyc&stb rise; it SHALL then deassert for at least one cycle before the next ack.
REQ-022 wbs_err_o and wbs_rty_o SHALL be 0.
REQ-023 The master SHALL issue only classic single transfers: cti=3'b000, bte=2'b00, sel=4'hF.
REQ-024 The master SHALL hold cyc, stb, adr, dat and we stable until ack or err; cyc and stb SHALL drop the cycle after termination.
REQ-025 wbm_rty_i SHALL be treated as "retry the same transfer next cycle".
REQ-026 FSM states and transitions:
- IDLE -> RD_SRC on start.
- RD_SRC (read SRC+4*i) -> WR_IN (write ACC_BASE+IN_OFS+4*i).
- WR_IN -> RD_SRC while i<LEN-1, else -> START.
- START (write 1 to ACC_BASE+CTRL_OFS) -> POLL.
- POLL (read ACC_BASE+STAT_OFS) -> RD_OUT when bit0=1, else repeat.
- RD_OUT (read ACC_BASE+OUT_OFS+4*i) -> WR_DST (write DST+4*i).
- WR_DST -> RD_OUT while i<LEN-1, else -> DONE.
- DONE: set done and irq -> IDLE.
REQ-027 Index i SHALL be 4 bits, reset to 0 on entry to RD_SRC from IDLE and on entry to RD_OUT from POLL, and increment after each WR_IN or WR_DST ack.
REQ-028 Read data SHALL be latched into a 32-bit holding register on ack and used as the next write's data.
REQ-029 A 10-bit poll counter SHALL increment per completed POLL read; reaching POLL_LIMIT with done=0 SHALL go to ERR.
REQ-030 wbm_err_i in any state SHALL go to ERR.
REQ-031 ERR SHALL drop cyc, set err and irq, and go to IDLE the next cycle.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Slave accesses and master transfers SHALL proceed concurrently without interaction.

Reset
REQ-034 Asserting rst_sys_n low SHALL immediately force IDLE, including mid-transfer.
REQ-035 Reset SHALL clear all registers and counters to 0 and LEN to 16.
REQ-036 Reset SHALL drive all wbm_* and wbs_* outputs and irq to 0.

Verification
REQ-037 SRC=0x1000, DST=0x2000, LEN=4, start; memory model returns 0xA0..0xA3; accelerator done on the 3rd poll -> 4 reads from 0x1000-0x100C, 4 writes to the IN window, 1 start write, 3 polls, 4 reads from OUT, 4 writes to 0x2000-0x200C; STAT=3'b001; irq=1.
REQ-038 Write LEN=0 and read it back -> 16; a 16-word job wraps i from 15 without overflow.
REQ-039 Accelerator never sets done -> exactly 1024 polls, then STAT=3'b010, irq=1, cyc=0.
REQ-040 wbm_err_i asserted on the 2nd WR_IN -> ERR; no START write issued; then CTRL=2 -> STAT=0, irq=0.
REQ-041 Start and SRC writes issued while busy -> ignored; the job completes with the original SRC.
REQ-042 rst_sys_n pulled low during POLL with cyc=1 -> cyc=0 asynchronously; after release, STAT=0 and LEN=16.
